mux_scan_seq: RTL and testbench



---
 rtl/mux_scan_seq_if.sv | 34 +++
 rtl/mux_scan_seq.sv | 152 +++++++++++++++
 tb/tb_mux_scan_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_seq_if.sv
//------------------------------------------------------------------------------
// Module  : mux_scan_seq_if
// Brief   : Control, status and mux-facing signals of the scan sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux_scan_seq_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [7:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         mux_data;
    logic [2:0]         addr;
    logic               sample;
    logic               busy;
    logic               done;
    logic [31:0]        frame;

    modport master (
        output start, stop, cont, ch_mask, dwell, mux_data,
        input  addr, sample, busy, done, frame
    );

    modport slave (
        input  start, stop, cont, ch_mask, dwell, mux_data,
        output addr, sample, busy, done, frame
    );
endinterface

`default_nettype wire

// File: rtl/mux_scan_seq.sv
//------------------------------------------------------------------------------
// Module  : mux_scan_seq
// Brief   : Walks enabled channels of an 8:1 nibble mux with a programmable
//           dwell and publishes one 32-bit frame per completed scan.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mux_scan_seq_if.slave   bus
);

    localparam logic [0:0]         S_IDLE  = 1'b0;
    localparam logic [0:0]         S_SCAN  = 1'b1;
    localparam logic [DWELL_W-1:0] c_one   = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [0:0]         r_state,  w_state_nxt;
    logic [2:0]         r_addr,   w_addr_nxt;
    logic [DWELL_W-1:0] r_cnt,    w_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell,  w_dwell_nxt;
    logic [7:0]         r_mask,   w_mask_nxt;
    logic               r_cont,   w_cont_nxt;
    logic [31:0]        r_buf,    w_buf_nxt;
    logic [31:0]        r_frame,  w_frame_nxt;
    logic               r_done,   w_done_nxt;

    logic               w_sample;
    logic [31:0]        w_buf_cap;
    logic [3:0]         w_next;

    // Index of the lowest set bit; callers guarantee a non-zero mask.
    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        f_lowest = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) f_lowest = 3'(k);
        end
    endfunction

    // {found, index} of the lowest set bit strictly above position a.
    function automatic logic [3:0] f_next_above(input logic [7:0] m, input logic [2:0] a);
        f_next_above = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && (k > int'(a))) f_next_above = {1'b1, 3'(k)};
        end
    endfunction

    assign w_sample = (r_state == S_SCAN) && (r_cnt == r_dwell);
    assign w_next   = f_next_above(r_mask, r_addr);

    always_comb begin
        w_buf_cap = r_buf;
        w_buf_cap[{r_addr, 2'b00} +: 4] = bus.mux_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 3'd0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_mask  <= 8'd0;
            r_cont  <= 1'b0;
            r_buf   <= 32'd0;
            r_frame <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
            r_mask  <= w_mask_nxt;
            r_cont  <= w_cont_nxt;
            r_buf   <= w_buf_nxt;
            r_frame <= w_frame_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell;
        w_mask_nxt  = r_mask;
        w_cont_nxt  = r_cont;
        w_buf_nxt   = r_buf;
        w_frame_nxt = r_frame;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_addr_nxt = 3'd0;
                w_cnt_nxt  = '0;
                if (bus.start && (bus.ch_mask != 8'd0)) begin
                    w_mask_nxt  = bus.ch_mask;
                    w_cont_nxt  = bus.cont;
                    w_dwell_nxt = bus.dwell;
                    w_buf_nxt   = 32'd0;
                    w_addr_nxt  = f_lowest(bus.ch_mask);
                    w_state_nxt = S_SCAN;
                end
            end

            S_SCAN: begin
                w_cnt_nxt = r_cnt + c_one;
                // Abort wins even over a frame-completing sample.
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_addr_nxt  = 3'd0;
                    w_cnt_nxt   = '0;
                    w_buf_nxt   = 32'd0;
                end else if (w_sample) begin
                    w_buf_nxt = w_buf_cap;
                    if (w_next[3]) begin
                        w_addr_nxt = w_next[2:0];
                        w_cnt_nxt  = '0;
                    end else begin
                        w_frame_nxt = w_buf_cap;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        if (r_cont) begin
                            w_addr_nxt = f_lowest(r_mask);
                            w_buf_nxt  = 32'd0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_addr_nxt  = 3'd0;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 3'd0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.addr   = r_addr;
    assign bus.sample = w_sample;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
    assign bus.frame  = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_mux_scan_seq
// Brief   : Directed self-checking bench for the mux scan sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_seq;

    logic       clk;
    logic       rst;
    logic [3:0] mux_tab [0:7];
    int         n_vec;
    int         n_err;

    mux_scan_seq_if #(.DWELL_W(8)) ifc ();

    mux_scan_seq #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // Behavioural mux: returns the nibble of whichever channel is selected.
    assign ifc.mux_data = mux_tab[ifc.addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (obs=timeout exp=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.stop = 1'b0;
        ifc.cont = 1'b0;
        ifc.ch_mask = 8'h00;
        ifc.dwell = 8'd0;
        for (int k = 0; k < 8; k++) mux_tab[k] = 4'h0;
        tick();
        tick();
        chk("rst_addr", 32'(ifc.addr), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_sample", 32'(ifc.sample), 32'd0);
        chk("rst_frame", ifc.frame, 32'd0);
        rst = 1'b0;
        tick();

        // Single shot over all channels, one cycle each
        for (int k = 0; k < 8; k++) mux_tab[k] = 4'(k + 1);
        ifc.ch_mask = 8'hFF;
        ifc.dwell = 8'd0;
        ifc.cont = 1'b0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t1_addr", 32'(ifc.addr), 32'(k));
            chk("t1_sample", 32'(ifc.sample), 32'd1);
            chk("t1_busy", 32'(ifc.busy), 32'd1);
            chk("t1_done_low", 32'(ifc.done), 32'd0);
            tick();
        end
        chk("t1_done", 32'(ifc.done), 32'd1);
        chk("t1_frame", ifc.frame, 32'h8765_4321);
        chk("t1_busy_drop", 32'(ifc.busy), 32'd0);
        chk("t1_addr_idle", 32'(ifc.addr), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(ifc.done), 32'd0);

        // Sparse mask, dwell 3; disabled channels carry junk that must not appear
        for (int k = 0; k < 8; k++) mux_tab[k] = 4'hF;
        mux_tab[2] = 4'hA;
        mux_tab[5] = 4'hB;
        mux_tab[7] = 4'hC;
        ifc.ch_mask = 8'b1010_0100;
        ifc.dwell = 8'd3;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("t2_addr", 32'(ifc.addr), (i < 4) ? 32'd2 : (i < 8) ? 32'd5 : 32'd7);
            chk("t2_sample", 32'(ifc.sample), ((i % 4) == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t2_done", 32'(ifc.done), 32'd1);
        chk("t2_frame", ifc.frame, 32'hC0B0_0A00);
        chk("t2_busy_drop", 32'(ifc.busy), 32'd0);

        // Continuous scan of channels 0 and 7, dwell 1, then stop mid-frame
        mux_tab[0] = 4'h3;
        mux_tab[7] = 4'h9;
        ifc.ch_mask = 8'h81;
        ifc.dwell = 8'd1;
        ifc.cont = 1'b1;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3_addr", 32'(ifc.addr), ((i % 4) < 2) ? 32'd0 : 32'd7);
            chk("t3_done", 32'(ifc.done), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) chk("t3_frame_a", ifc.frame, 32'h9000_0003);
            tick();
        end
        chk("t3_done_b", 32'(ifc.done), 32'd1);
        chk("t3_frame_b", ifc.frame, 32'h9000_0003);
        chk("t3_busy_cont", 32'(ifc.busy), 32'd1);
        chk("t3_addr_wrap", 32'(ifc.addr), 32'd0);
        mux_tab[0] = 4'h5;
        tick();
        chk("t3_sample_ch0", 32'(ifc.sample), 32'd1);
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        chk("t3_stop_busy", 32'(ifc.busy), 32'd0);
        chk("t3_stop_addr", 32'(ifc.addr), 32'd0);
        chk("t3_stop_done", 32'(ifc.done), 32'd0);
        chk("t3_stop_frame", ifc.frame, 32'h9000_0003);

        // Stop coinciding with the frame-completing sample
        mux_tab[0] = 4'h1;
        mux_tab[1] = 4'h2;
        ifc.ch_mask = 8'h03;
        ifc.dwell = 8'd0;
        ifc.cont = 1'b0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk("t4_addr0", 32'(ifc.addr), 32'd0);
        tick();
        chk("t4_addr1", 32'(ifc.addr), 32'd1);
        chk("t4_sample", 32'(ifc.sample), 32'd1);
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        chk("t4_busy", 32'(ifc.busy), 32'd0);
        chk("t4_done", 32'(ifc.done), 32'd0);
        chk("t4_frame", ifc.frame, 32'h9000_0003);
        tick();
        chk("t4_done_late", 32'(ifc.done), 32'd0);

        // Start with empty mask is ignored
        ifc.ch_mask = 8'h00;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk("t5_empty_busy", 32'(ifc.busy), 32'd0);
        tick();
        chk("t5_empty_done", 32'(ifc.done), 32'd0);

        // Start held high while busy, controls changed mid-scan: no effect
        mux_tab[1] = 4'h4;
        mux_tab[2] = 4'h6;
        ifc.ch_mask = 8'h06;
        ifc.dwell = 8'd1;
        ifc.cont = 1'b0;
        ifc.start = 1'b1;
        tick();
        chk("t5_busy", 32'(ifc.busy), 32'd1);
        ifc.ch_mask = 8'hFF;
        ifc.dwell = 8'd0;
        ifc.cont = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_addr", 32'(ifc.addr), (i < 2) ? 32'd1 : 32'd2);
            if (i == 3) ifc.start = 1'b0;
            tick();
        end
        chk("t5_done", 32'(ifc.done), 32'd1);
        chk("t5_busy_drop", 32'(ifc.busy), 32'd0);
        chk("t5_frame", ifc.frame, 32'h0000_0640);
        tick();
        chk("t5_no_restart", 32'(ifc.busy), 32'd0);

        // Reset in the middle of a scan
        ifc.ch_mask = 8'hFF;
        ifc.dwell = 8'd2;
        ifc.cont = 1'b0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        tick();
        chk("t6_busy_pre", 32'(ifc.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_addr", 32'(ifc.addr), 32'd0);
        chk("t6_busy", 32'(ifc.busy), 32'd0);
        chk("t6_done", 32'(ifc.done), 32'd0);
        chk("t6_sample", 32'(ifc.sample), 32'd0);
        chk("t6_frame", ifc.frame, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
